// File: rtl/symbol_serializer_pkg.sv
// Shared types and constants for the symbol serializer and its benches.
package symbol_serializer_pkg;

  // Default encoded symbol width (one 8b/10b code group).
  localparam int SYMBOL_W_DEF = 10;

  // K28.5 comma code group in both running disparities, bit 9 = 'a'.
  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sym_hold_buffer.sv
// One-entry valid/ready hold buffer that stages the next symbol for the
// serializer. Ready is simply "not full", so a push and a pop can never
// land on the same edge.
module sym_hold_buffer
  import symbol_serializer_pkg::*;
#(
  parameter int SYMBOL_W = SYMBOL_W_DEF
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic [SYMBOL_W-1:0] iSymbol,
  input  logic                iValid,
  output logic                oReady,
  input  logic                iPop,
  output logic [SYMBOL_W-1:0] oData,
  output logic                oFull
);

  logic                full;
  logic [SYMBOL_W-1:0] data;

  assign oReady = ~full;
  assign oFull  = full;
  assign oData  = data;

  // Capture on a valid/ready handshake, release when the serializer loads.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (iValid && !full) begin
      full <= 1'b1;
      data <= iSymbol;
    end else if (iPop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/symbol_serializer.sv
// Parallel-to-serial converter for encoded symbols, MSB ('a') first.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | line parked at 0, waiting for a held symbol while enabled
//   SHIFT | shift_reg MSB on the line, bit_cnt = index of current bit
//
// The line bit is the MSB flop of the shift register itself, so it is a
// registered output and drops to 0 whenever the register is cleared.
module symbol_serializer
  import symbol_serializer_pkg::*;
#(
  parameter int SYMBOL_W = SYMBOL_W_DEF
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic                iEnable,
  input  logic [SYMBOL_W-1:0] iSymbol,
  input  logic                iValid,
  output logic                oReady,
  output logic                oSerial,
  output logic                oTxIdle,
  output logic                oSymStart,
  output logic                oUnderflow,
  input  logic                iClearUnderflow
);

  localparam int               CNT_W    = (SYMBOL_W > 1) ? $clog2(SYMBOL_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_W - 1);

  ser_state_t          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SYMBOL_W-1:0] shift_reg;
  logic [SYMBOL_W-1:0] hold_data;
  logic                hold_full;
  logic                last_bit;
  logic                load_now;

  // A new symbol is pulled either from idle or on the last bit of the
  // current one, which is what keeps back-to-back symbols gap-free.
  assign last_bit = (bit_cnt == CNT_LAST);
  assign load_now = iEnable && hold_full &&
                    ((state == IDLE) || ((state == SHIFT) && last_bit));

  assign oSerial = shift_reg[SYMBOL_W-1];

  sym_hold_buffer #(
    .SYMBOL_W (SYMBOL_W)
  ) u_hold (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iSymbol  (iSymbol),
    .iValid   (iValid),
    .oReady   (oReady),
    .iPop     (load_now),
    .oData    (hold_data),
    .oFull    (hold_full)
  );

  // Serializer FSM: load, shift and end-of-symbol handling; frozen while disabled.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      oTxIdle    <= 1'b1;
      oSymStart  <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      oSymStart <= 1'b0;
      // Clear first so a same-edge underflow below overrides it.
      if (iClearUnderflow) begin
        oUnderflow <= 1'b0;
      end
      if (load_now) begin
        state     <= SHIFT;
        shift_reg <= hold_data;
        bit_cnt   <= '0;
        oTxIdle   <= 1'b0;
        oSymStart <= 1'b1;
      end else if (iEnable) begin
        case (state)
          IDLE: begin
            shift_reg <= '0;
            oTxIdle   <= 1'b1;
          end
          SHIFT: begin
            if (last_bit) begin
              state      <= IDLE;
              shift_reg  <= '0;
              bit_cnt    <= '0;
              oTxIdle    <= 1'b1;
              oUnderflow <= 1'b1;
            end else begin
              shift_reg <= {shift_reg[SYMBOL_W-2:0], 1'b0};
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end
          end
          default: begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            oTxIdle   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_symbol_serializer.sv
// Directed bench for symbol_serializer with hand-computed bit streams.
module tb_symbol_serializer;
  import symbol_serializer_pkg::*;

  logic       iClk = 1'b0;
  logic       iReset_n;
  logic       iEnable;
  logic [9:0] iSymbol;
  logic       iValid;
  logic       oReady;
  logic       oSerial;
  logic       oTxIdle;
  logic       oSymStart;
  logic       oUnderflow;
  logic       iClearUnderflow;

  int n_tests = 0;
  int n_fail  = 0;

  symbol_serializer #(.SYMBOL_W(10)) dut (
    .iClk            (iClk),
    .iReset_n        (iReset_n),
    .iEnable         (iEnable),
    .iSymbol         (iSymbol),
    .iValid          (iValid),
    .oReady          (oReady),
    .oSerial         (oSerial),
    .oTxIdle         (oTxIdle),
    .oSymStart       (oSymStart),
    .oUnderflow      (oUnderflow),
    .iClearUnderflow (iClearUnderflow)
  );

  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Offer a symbol to an idle, empty serializer; returns with its first bit on the line.
  task automatic send_first(input logic [9:0] sym);
    iSymbol = sym;
    iValid  = 1'b1;
    tick();
    check_eq("accept ready", 32'(oReady), 32'd0);
    iValid = 1'b0;
    tick();
  endtask

  task automatic clear_unf();
    iClearUnderflow = 1'b1;
    tick();
    iClearUnderflow = 1'b0;
    check_eq("unf cleared", 32'(oUnderflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] s;
    logic [9:0]  q[$];
    logic [9:0]  sym, acc, exp_sym;
    logic        take;
    int          nacc, nrx, nb;

    iReset_n = 1'b0;
    iEnable = 1'b0;
    iSymbol = '0;
    iValid = 1'b0;
    iClearUnderflow = 1'b0;
    tick();
    tick();
    check_eq("rst serial", 32'(oSerial), 32'd0);
    check_eq("rst txidle", 32'(oTxIdle), 32'd1);
    check_eq("rst symstart", 32'(oSymStart), 32'd0);
    check_eq("rst unf", 32'(oUnderflow), 32'd0);
    check_eq("rst ready", 32'(oReady), 32'd1);
    iReset_n = 1'b1;
    iEnable  = 1'b1;
    tick();

    // Single K28.5 RD- symbol then underflow.
    s = {K28_5_RDN, 10'h000};
    send_first(K28_5_RDN);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("t1 bit%0d", i), 32'(oSerial), 32'(s[19-i]));
      check_eq($sformatf("t1 sop%0d", i), 32'(oSymStart), 32'(i == 0));
      check_eq($sformatf("t1 busy%0d", i), 32'(oTxIdle), 32'd0);
      tick();
    end
    check_eq("t1 idle", 32'(oTxIdle), 32'd1);
    check_eq("t1 line", 32'(oSerial), 32'd0);
    check_eq("t1 unf", 32'(oUnderflow), 32'd1);
    clear_unf();

    // Back-to-back RD- then RD+, refilled right after the first load.
    s = {K28_5_RDN, K28_5_RDP};
    send_first(K28_5_RDN);
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        iSymbol = K28_5_RDP;
        iValid  = 1'b1;
      end
      check_eq($sformatf("t2 bit%0d", i), 32'(oSerial), 32'(s[19-i]));
      check_eq($sformatf("t2 sop%0d", i), 32'(oSymStart), 32'(i == 0 || i == 10));
      check_eq($sformatf("t2 busy%0d", i), 32'(oTxIdle), 32'd0);
      check_eq($sformatf("t2 unf%0d", i), 32'(oUnderflow), 32'd0);
      tick();
      if (i == 0) begin
        check_eq("t2 acc", 32'(oReady), 32'd0);
        iValid = 1'b0;
      end
    end
    check_eq("t2 idle", 32'(oTxIdle), 32'd1);
    check_eq("t2 unf end", 32'(oUnderflow), 32'd1);
    clear_unf();

    // Enable dropped for 5 cycles mid-symbol; next symbol accepted while frozen.
    s = {K28_5_RDN, K28_5_RDP};
    send_first(K28_5_RDN);
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("t3 bit%0d", i), 32'(oSerial), 32'(s[19-i]));
      check_eq($sformatf("t3 sop%0d", i), 32'(oSymStart), 32'(i == 0 || i == 10));
      if (i == 6) begin
        iEnable = 1'b0;
        iSymbol = K28_5_RDP;
        iValid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
          tick();
          iValid = 1'b0;
          check_eq($sformatf("t3 hold%0d", k), 32'(oSerial), 32'(s[13]));
          check_eq($sformatf("t3 hbusy%0d", k), 32'(oTxIdle), 32'd0);
          check_eq($sformatf("t3 hsop%0d", k), 32'(oSymStart), 32'd0);
          check_eq($sformatf("t3 hfull%0d", k), 32'(oReady), 32'd0);
        end
        iEnable = 1'b1;
      end
      tick();
    end
    check_eq("t3 idle", 32'(oTxIdle), 32'd1);
    check_eq("t3 unf", 32'(oUnderflow), 32'd1);
    clear_unf();

    // Reset at bit 4 of RD+ with RD- held: both are discarded.
    s = {K28_5_RDP, 10'h000};
    send_first(K28_5_RDP);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        iSymbol = K28_5_RDN;
        iValid  = 1'b1;
      end
      check_eq($sformatf("t4 bit%0d", i), 32'(oSerial), 32'(s[19-i]));
      tick();
      iValid = 1'b0;
    end
    check_eq("t4 held", 32'(oReady), 32'd0);
    #2 iReset_n = 1'b0;
    #1;
    check_eq("t4 rst serial", 32'(oSerial), 32'd0);
    check_eq("t4 rst txidle", 32'(oTxIdle), 32'd1);
    check_eq("t4 rst sop", 32'(oSymStart), 32'd0);
    check_eq("t4 rst unf", 32'(oUnderflow), 32'd0);
    check_eq("t4 rst ready", 32'(oReady), 32'd1);
    tick();
    iReset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      check_eq($sformatf("t4 quiet%0d", k), 32'(oSerial), 32'd0);
      check_eq($sformatf("t4 qidle%0d", k), 32'(oTxIdle), 32'd1);
      check_eq($sformatf("t4 qready%0d", k), 32'(oReady), 32'd1);
    end

    // Underflow set wins over a same-edge clear; a lone clear then drops it.
    send_first(K28_5_RDN);
    repeat (10) tick();
    check_eq("t5 unf set", 32'(oUnderflow), 32'd1);
    send_first(K28_5_RDP);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) iClearUnderflow = 1'b1;
      tick();
    end
    check_eq("t5 set wins", 32'(oUnderflow), 32'd1);
    check_eq("t5 idle", 32'(oTxIdle), 32'd1);
    tick();
    iClearUnderflow = 1'b0;
    check_eq("t5 clear", 32'(oUnderflow), 32'd0);

    // Continuous iValid with random symbols: received stream must match in order.
    nacc = 0;
    nrx  = 0;
    nb   = 0;
    acc  = '0;
    iSymbol = 10'($urandom_range(0, 1023));
    iValid  = 1'b1;
    for (int cyc = 0; cyc < 400 && nrx < 12; cyc++) begin
      take = oReady && iValid;
      sym  = iSymbol;
      tick();
      if (take) begin
        q.push_back(sym);
        nacc++;
        if (nacc == 12) iValid = 1'b0;
        else iSymbol = 10'($urandom_range(0, 1023));
      end
      if (!oTxIdle) begin
        check_eq("t6 sop", 32'(oSymStart), 32'(nb == 0));
        check_eq("t6 unf", 32'(oUnderflow), 32'd0);
        acc = {acc[8:0], oSerial};
        nb++;
        if (nb == 10) begin
          exp_sym = (q.size() > 0) ? q.pop_front() : 10'bx;
          check_eq($sformatf("t6 sym%0d", nrx), 32'(acc), 32'(exp_sym));
          nrx++;
          nb = 0;
        end
      end
    end
    check_eq("t6 count", 32'(nrx), 32'd12);
    tick();
    check_eq("t6 idle", 32'(oTxIdle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/symbol_serializer.md
SYMBOL_SERIALIZER -- requirements
Module: symbol_serializer

Interface
REQ-001 The block SHALL have parameter SYMBOL_W, default 10, giving the encoded symbol width in bits.
REQ-002 The block SHALL have port iClk  input  1  bit-rate clock; all logic is on the rising edge.
REQ-003 The block SHALL have port iReset_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port iEnable  input  1  serializer run enable.
REQ-005 The block SHALL have port iSymbol  input  SYMBOL_W  encoded symbol from the 8b/10b encoder, bit 9 = 'a', bit 0 = 'j'.
REQ-006 The block SHALL have port iValid  input  1  iSymbol is valid.
REQ-007 The block SHALL have port oReady  output  1  hold buffer can accept a symbol.
REQ-008 The block SHALL have port oSerial  output  1  registered serial line bit.
REQ-009 The block SHALL have port oTxIdle  output  1  high while no symbol is being shifted.
REQ-010 The block SHALL have port oSymStart  output  1  one-cycle pulse coincident with the first bit of each symbol on oSerial.
REQ-011 The block SHALL have port oUnderflow  output  1  sticky flag for a gap between symbols.
REQ-012 The block SHALL have port iClearUnderflow  input  1  clears oUnderflow.

Function
REQ-013 The block SHALL hold one symbol in a hold buffer and shift from a separate SYMBOL_W-bit shift register, with a bit counter of 0..SYMBOL_W-1.
REQ-014 oReady SHALL equal NOT hold_full; a transfer SHALL occur only when iValid and oReady are both high; there is no bypass into the shift register.
REQ-015 The FSM SHALL have the states IDLE and SHIFT.
REQ-016 In IDLE, oSerial SHALL be 0 and oTxIdle SHALL be 1; when iEnable and hold_full are both high at an edge, the shift register SHALL load from the hold buffer, hold_full SHALL clear, the counter SHALL be set to 0, and the FSM SHALL enter SHIFT.
REQ-017 In SHIFT, oSerial SHALL present the shift-register MSB, so bits go out MSB first ('a' first); each enabled edge SHALL shift left one bit and increment the counter.
REQ-018 At counter = SYMBOL_W-1 with iEnable high, if hold_full: the next symbol SHALL be loaded, the counter SHALL be set to 0, the FSM SHALL stay in SHIFT, and there SHALL be no gap bit.
REQ-019 At counter = SYMBOL_W-1 with iEnable high, if the hold buffer is empty: the FSM SHALL enter IDLE and oUnderflow SHALL be set.
REQ-020 oSymStart SHALL be high for exactly the cycle in which bit 9 of a newly loaded symbol is on oSerial.
REQ-021 Latency: a symbol accepted at edge N while IDLE and enabled SHALL have its first bit on oSerial in the cycle after edge N+1.
REQ-022 Throughput: the block SHALL sustain one symbol per SYMBOL_W cycles with no gaps whenever the upstream refills the hold buffer within SYMBOL_W-1 cycles of each load.
REQ-023 When iEnable is low, the FSM, counter, shift register and oSerial SHALL freeze, and the hold buffer SHALL still accept a symbol.
REQ-024 oUnderflow SHALL be cleared by iClearUnderflow; a set on the same edge as a clear SHALL take priority.

Reset
REQ-025 When iReset_n is low, the block SHALL asynchronously set state = IDLE, counter = 0, shift register = 0, hold_full = 0, oSerial = 0, oTxIdle = 1, oSymStart = 0, oUnderflow = 0, and oReady SHALL then be 1.
REQ-026 A reset in the middle of a symbol SHALL discard both the partial symbol and the held symbol, and the first enabled edge after release SHALL see IDLE.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, SHIFT), the SYMBOL_W default, and the K28.5 constants 10'h0FA (RD-) and 10'h305 (RD+) for benches.
REQ-028 The one-entry valid/ready hold buffer SHALL be implemented as sub-module sym_hold_buffer; the FSM, counter and shift register SHALL stay in symbol_serializer.

Verification
REQ-029 Bench: after reset, drive iEnable=1 and a single 0x0FA -> oSerial sequence 0,0,1,1,1,1,1,0,1,0 starting two cycles after acceptance, oSymStart on the first bit, then IDLE and oUnderflow=1.
REQ-030 Bench: drive 0x0FA then 0x305 back-to-back with refill within 9 cycles -> 20 contiguous bits, oSymStart pulses exactly 10 cycles apart, oTxIdle low throughout, oUnderflow stays 0.
REQ-031 Bench: drop iEnable for 5 cycles in the middle of a symbol -> oSerial and the counter hold, and the remaining bits resume unchanged.
REQ-032 Bench: pull iReset_n low at bit 4 of 0x305 while a symbol is held -> all outputs take their reset values immediately, oReady=1 after reset, and no bits of either symbol are sent.
REQ-033 Bench: with oUnderflow=1, assert iClearUnderflow on the same edge as a new underflow -> oUnderflow remains 1; assert iClearUnderflow alone -> oUnderflow becomes 0.
REQ-034 Bench: hold iValid=1 continuously with random symbols -> the received bit stream equals the accepted symbols in order, MSB first, with no loss or duplication.
